reset_seq_ctrl: RTL



---
 rtl/reset_seq_ctrl_pkg.sv | 28 ++
 rtl/reset_seq_ctrl_req.sv | 49 ++++
 rtl/reset_seq_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/reset_seq_ctrl_pkg.sv
// Shared types and sizing helpers for the reset sequencer.
package reset_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ASSERT,
    ST_RELEASE,
    ST_ACK
  } state_e;

  localparam int unsigned DEF_N_REQ = 4;

  // Power-on is reported one bit above the highest requester.
  function automatic int unsigned power_on_cause_idx(input int unsigned n_req);
    return n_req;
  endfunction

  localparam int unsigned POWER_ON_CAUSE_IDX = power_on_cause_idx(DEF_N_REQ);

  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_seq_ctrl_req.sv
// Request edge detection, masking and pending-cause accumulation.
module reset_seq_ctrl_req
  import reset_seq_ctrl_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_REQ-1:0] req_i,
  input  logic [N_REQ-1:0] req_mask_i,
  input  logic             clear_i,
  input  logic             merge_en_i,
  output logic             edge_any_o,
  output logic [N_REQ:0]   pending_o
);

  localparam int unsigned   PON_IDX  = power_on_cause_idx(N_REQ);
  localparam logic [N_REQ:0] PON_MASK = (N_REQ+1)'(1) << PON_IDX;

  logic [N_REQ-1:0] req_q;
  logic [N_REQ-1:0] edge_w;
  logic [N_REQ:0]   pending_q;
  logic [N_REQ:0]   pending_d;

  // req_q tracks the raw line, so a bit masked at its rising edge is never seen later.
  assign edge_w     = req_i & ~req_q & ~req_mask_i;
  assign edge_any_o = |edge_w;
  assign pending_o  = pending_q;

  always_comb begin
    pending_d = pending_q;
    if (clear_i) begin
      pending_d = {1'b0, edge_w};
    end else if (merge_en_i) begin
      pending_d = pending_q | {1'b0, edge_w};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      req_q     <= '0;
      pending_q <= PON_MASK;
    end else begin
      req_q     <= req_i;
      pending_q <= pending_d;
    end
  end

endmodule

// File: rtl/reset_seq_ctrl.sv
// Reset sequencer: arbitrates reset requests, holds all domains in reset,
// releases them in index order and acknowledges the served requesters.
module reset_seq_ctrl
  import reset_seq_ctrl_pkg::*;
#(
  parameter int unsigned N_REQ         = 4,
  parameter int unsigned N_DOMAINS     = 3,
  parameter int unsigned ASSERT_CYCLES = 16,
  parameter int unsigned STAGE_GAP     = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_REQ-1:0]     req_i,
  input  logic [N_REQ-1:0]     req_mask_i,
  output logic [N_DOMAINS-1:0] domain_reset_n_o,
  output logic [N_DOMAINS-1:0] domain_reset_o,
  output logic                 busy_o,
  output logic [N_REQ-1:0]     ack_o,
  output logic [N_REQ:0]       last_cause_o
);

  localparam int unsigned CNT_W = clog2_min1(max_u(ASSERT_CYCLES, STAGE_GAP));
  localparam int unsigned STG_W = clog2_min1(N_DOMAINS);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [STG_W-1:0]     stage_q, stage_d;
  logic [N_DOMAINS-1:0] dom_q, dom_d;
  logic                 busy_q, busy_d;
  logic [N_REQ-1:0]     ack_q, ack_d;
  logic [N_REQ:0]       last_cause_q;
  logic                 edge_any;
  logic [N_REQ:0]       pending;

  reset_seq_ctrl_req #(.N_REQ(N_REQ)) u_req (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_i      (req_i),
    .req_mask_i (req_mask_i),
    .clear_i    (state_q == ST_ACK),
    .merge_en_i (state_q != ST_ACK),
    .edge_any_o (edge_any),
    .pending_o  (pending)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    dom_d   = dom_q;
    case (state_q)
      ST_IDLE: begin
        if (edge_any) begin
          state_d = ST_ASSERT;
          cnt_d   = '0;
          dom_d   = '0;
        end
      end
      ST_ASSERT: begin
        dom_d = '0;
        if (cnt_q == CNT_W'(ASSERT_CYCLES - 1)) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
          stage_d = '0;
          dom_d   = N_DOMAINS'(1);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RELEASE: begin
        // A new request aborts the release and restarts the full hold time.
        if (edge_any) begin
          state_d = ST_ASSERT;
          cnt_d   = '0;
          stage_d = '0;
          dom_d   = '0;
        end else if (cnt_q == CNT_W'(STAGE_GAP - 1)) begin
          cnt_d = '0;
          if (stage_q < STG_W'(N_DOMAINS - 1)) begin
            stage_d = stage_q + 1'b1;
            dom_d   = dom_q | (N_DOMAINS'(1) << (stage_q + 1'b1));
          end else begin
            state_d = ST_ACK;
            stage_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_ACK: begin
        cnt_d   = '0;
        stage_d = '0;
        if (edge_any) begin
          state_d = ST_ASSERT;
          dom_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_ASSERT;
        cnt_d   = '0;
        stage_d = '0;
        dom_d   = '0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
    ack_d  = (state_d == ST_ACK) ? pending[N_REQ-1:0] : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_ASSERT;
      cnt_q        <= '0;
      stage_q      <= '0;
      dom_q        <= '0;
      busy_q       <= 1'b1;
      ack_q        <= '0;
      last_cause_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      dom_q   <= dom_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      if (state_q == ST_ACK) begin
        last_cause_q <= pending;
      end
    end
  end

  assign domain_reset_n_o = dom_q;
  assign domain_reset_o   = ~dom_q;
  assign busy_o           = busy_q;
  assign ack_o            = ack_q;
  assign last_cause_o     = last_cause_q;

endmodule
